// File: rtl/oled_pwr_seq.sv
// SSD1306 power-up/power-down sequencer driving oled_spi over an 8-bit WB master; muxes the CPU slave port onto the same bus.
// Latency: start_i/stop_i take effect next cycle; each master transfer is followed by >=1 idle cycle (or the programmed WAIT).
// Backpressure: master holds cyc/stb until m_ack_i; CPU cycles stall (no ack) while the sequencer owns the bus.
// Optional: OLED_SEQ_TIMEOUT_EN bounds SPSR polling to 4096 reads and adds an ERR state driving err_o.
module oled_pwr_seq #(
    parameter int unsigned T_VDD_CYC  = 100000,
    parameter int unsigned T_RES_CYC  = 1000,
    parameter int unsigned T_VBAT_CYC = 10000000,
    parameter logic [7:0]  SPCR_VAL   = 8'h50
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic       stop_i,
    output logic       busy_o,
    output logic       ready_o,
    output logic       err_o,
    input  logic       s_cyc_i,
    input  logic       s_stb_i,
    input  logic       s_we_i,
    input  logic [2:0] s_adr_i,
    input  logic [7:0] s_dat_i,
    output logic [7:0] s_dat_o,
    output logic       s_ack_o,
    output logic       m_cyc_o,
    output logic       m_stb_o,
    output logic       m_we_o,
    output logic [2:0] m_adr_o,
    output logic [7:0] m_dat_o,
    input  logic [7:0] m_dat_i,
    input  logic       m_ack_i
);
    localparam logic [2:0] ST_OFF   = 3'd0;
    localparam logic [2:0] ST_PWRUP = 3'd1;
    localparam logic [2:0] ST_ON    = 3'd2;
    localparam logic [2:0] ST_PWRDN = 3'd3;
`ifdef OLED_SEQ_TIMEOUT_EN
    localparam logic [2:0] ST_ERR   = 3'd4;
`endif
    localparam logic [1:0] PH_IDLE = 2'd0;
    localparam logic [1:0] PH_GAP  = 2'd1;
    localparam logic [1:0] PH_BUS  = 2'd2;
    // Step kinds: plain register write, SEND(byte), WAIT(selector), END(target state)
    localparam logic [1:0] K_WR   = 2'd0;
    localparam logic [1:0] K_SEND = 2'd1;
    localparam logic [1:0] K_WAIT = 2'd2;
    localparam logic [1:0] K_END  = 2'd3;
    localparam logic [4:0] PC_OFF = 5'd21;
`ifdef OLED_SEQ_TIMEOUT_EN
    localparam logic [4:0] PC_ERR = 5'd26;
`endif

    // Step ROM word: {kind[1:0], adr[2:0], dat[7:0]}
    function automatic logic [12:0] rom(input logic [4:0] idx);
        case (idx)
            5'd0:  rom = {K_WR,   3'd5, 8'h0F};
            5'd1:  rom = {K_WR,   3'd0, SPCR_VAL};
            5'd2:  rom = {K_WR,   3'd5, 8'h06};
            5'd3:  rom = {K_WAIT, 3'd0, 8'h00};
            5'd4:  rom = {K_SEND, 3'd0, 8'hAE};
            5'd5:  rom = {K_WR,   3'd5, 8'h04};
            5'd6:  rom = {K_WAIT, 3'd0, 8'h01};
            5'd7:  rom = {K_WR,   3'd5, 8'h06};
            5'd8:  rom = {K_WAIT, 3'd0, 8'h01};
            5'd9:  rom = {K_SEND, 3'd0, 8'h8D};
            5'd10: rom = {K_SEND, 3'd0, 8'h14};
            5'd11: rom = {K_SEND, 3'd0, 8'hD9};
            5'd12: rom = {K_SEND, 3'd0, 8'hF1};
            5'd13: rom = {K_WR,   3'd5, 8'h02};
            5'd14: rom = {K_WAIT, 3'd0, 8'h02};
            5'd15: rom = {K_SEND, 3'd0, 8'hA1};
            5'd16: rom = {K_SEND, 3'd0, 8'hC8};
            5'd17: rom = {K_SEND, 3'd0, 8'hDA};
            5'd18: rom = {K_SEND, 3'd0, 8'h20};
            5'd19: rom = {K_SEND, 3'd0, 8'hAF};
            5'd20: rom = {K_END,  3'd0, 8'h01};
            5'd21: rom = {K_SEND, 3'd0, 8'hAE};
            5'd22: rom = {K_WR,   3'd5, 8'h06};
            5'd23: rom = {K_WAIT, 3'd0, 8'h02};
            5'd24: rom = {K_WR,   3'd5, 8'h0F};
            5'd25: rom = {K_END,  3'd0, 8'h00};
`ifdef OLED_SEQ_TIMEOUT_EN
            5'd26: rom = {K_WR,   3'd5, 8'h0F};
            5'd27: rom = {K_END,  3'd0, 8'h02};
`endif
            default: rom = {K_END, 3'd0, 8'h00};
        endcase
    endfunction

    // Gap-counter load for a WAIT step; a zero wait still leaves the one mandatory idle cycle
    function automatic logic [31:0] wait_load(input logic [10:0] sel);
        logic [31:0] n;
        case (sel)
            11'd0:   n = T_VDD_CYC;
            11'd1:   n = T_RES_CYC;
            11'd2:   n = T_VBAT_CYC;
            default: n = 32'd0;
        endcase
        wait_load = (n == 32'd0) ? 32'd1 : n;
    endfunction

    logic [2:0]  state_q, state_d;
    logic [1:0]  phase_q, phase_d;
    logic [4:0]  pc_q, pc_d;
    logic [1:0]  sstep_q, sstep_d;   // SEND sub-step: 0 SPDR write, 1 SPSR poll, 2 SPIF clear
    logic [31:0] cnt_q, cnt_d;       // idle cycles remaining before the next step
    logic        pend_q, pend_d;     // stop requested during power-up
    logic        grant_q, grant_d;   // 1 = sequencer owns the slave bus
`ifdef OLED_SEQ_TIMEOUT_EN
    logic        err_q, err_d;
    logic [11:0] poll_q, poll_d;
`endif
    logic [12:0] op, nxt_op;
    logic        seq_cyc, seq_we;
    logic [2:0]  seq_adr;
    logic [7:0]  seq_dat;

    assign op     = rom(pc_q);
    assign nxt_op = rom(pc_q + 5'd1);
    assign busy_o  = (state_q == ST_PWRUP) || (state_q == ST_PWRDN);
    assign ready_o = (state_q == ST_ON);
`ifdef OLED_SEQ_TIMEOUT_EN
    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    // Next-state: arbitration, command stepping, SEND handshake and END dispatch
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        pc_d    = pc_q;
        sstep_d = sstep_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        grant_d = grant_q;
`ifdef OLED_SEQ_TIMEOUT_EN
        err_d   = err_q;
        poll_d  = poll_q;
`endif
        // Take the bus only between CPU cycles; hand it back once our own cycle is closed
        if (busy_o) begin
            if (!s_cyc_i) grant_d = 1'b1;
        end else if (phase_q != PH_BUS) begin
            grant_d = 1'b0;
        end

        case (state_q)
            ST_OFF: begin
                if (start_i) begin
                    state_d = ST_PWRUP;
                    pc_d    = 5'd0;
                    phase_d = PH_GAP;
                    cnt_d   = 32'd1;
                    sstep_d = 2'd0;
                    pend_d  = stop_i;
                end
            end
            ST_ON: begin
                if (stop_i) begin
                    state_d = ST_PWRDN;
                    pc_d    = PC_OFF;
                    phase_d = PH_GAP;
                    cnt_d   = 32'd1;
                    sstep_d = 2'd0;
                end
            end
`ifdef OLED_SEQ_TIMEOUT_EN
            ST_ERR: begin
                if (start_i) begin
                    state_d = ST_PWRUP;
                    err_d   = 1'b0;
                    pc_d    = 5'd0;
                    phase_d = PH_GAP;
                    cnt_d   = 32'd1;
                    sstep_d = 2'd0;
                    pend_d  = stop_i;
                end
            end
`endif
            ST_PWRUP, ST_PWRDN: begin
                if ((state_q == ST_PWRUP) && stop_i) pend_d = 1'b1;
                case (phase_q)
                    PH_GAP: begin
                        if (cnt_q > 32'd1) begin
                            cnt_d = cnt_q - 32'd1;
                        end else if (grant_q) begin
                            case (op[12:11])
                                K_END: begin
                                    pend_d  = 1'b0;
                                    phase_d = PH_IDLE;
                                    if (op[7:0] == 8'h01) begin
                                        if (pend_q || stop_i) begin
                                            state_d = ST_PWRDN;
                                            pc_d    = PC_OFF;
                                            phase_d = PH_GAP;
                                            cnt_d   = 32'd1;
                                        end else begin
                                            state_d = ST_ON;
                                        end
`ifdef OLED_SEQ_TIMEOUT_EN
                                    end else if (op[7:0] == 8'h02) begin
                                        state_d = ST_ERR;
                                        err_d   = 1'b1;
`endif
                                    end else begin
                                        state_d = ST_OFF;
                                    end
                                end
                                K_WAIT: begin
                                    pc_d  = pc_q + 5'd1;
                                    cnt_d = wait_load(op[10:0]);
                                end
                                default: phase_d = PH_BUS;
                            endcase
                        end
                    end
                    PH_BUS: begin
                        if (m_ack_i) begin
                            phase_d = PH_GAP;
                            cnt_d   = 32'd1;
                            if ((op[12:11] == K_SEND) && (sstep_q != 2'd2)) begin
                                if (sstep_q == 2'd0) begin
                                    sstep_d = 2'd1;
`ifdef OLED_SEQ_TIMEOUT_EN
                                    poll_d  = 12'd0;
`endif
                                end else if (m_dat_i[7]) begin
                                    sstep_d = 2'd2;
                                end else begin
`ifdef OLED_SEQ_TIMEOUT_EN
                                    if (poll_q == 12'hFFF) begin
                                        pc_d    = PC_ERR;
                                        sstep_d = 2'd0;
                                    end else begin
                                        poll_d = poll_q + 12'd1;
                                    end
`endif
                                end
                            end else begin
                                // Step finished; fold a following WAIT into this gap so it costs exactly N idle cycles
                                sstep_d = 2'd0;
                                if (nxt_op[12:11] == K_WAIT) begin
                                    pc_d  = pc_q + 5'd2;
                                    cnt_d = wait_load(nxt_op[10:0]);
                                end else begin
                                    pc_d = pc_q + 5'd1;
                                end
                            end
                        end
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    // Sequencer-side master cycle contents for the current step
    always_comb begin
        seq_cyc = (phase_q == PH_BUS);
        seq_we  = 1'b0;
        seq_adr = 3'd0;
        seq_dat = 8'h00;
        if (seq_cyc) begin
            if (op[12:11] == K_SEND) begin
                case (sstep_q)
                    2'd0:    begin seq_we = 1'b1; seq_adr = 3'd2; seq_dat = op[7:0]; end
                    2'd1:    begin seq_we = 1'b0; seq_adr = 3'd1; end
                    default: begin seq_we = 1'b1; seq_adr = 3'd1; seq_dat = 8'h80; end
                endcase
            end else begin
                seq_we  = 1'b1;
                seq_adr = op[10:8];
                seq_dat = op[7:0];
            end
        end
    end

    // Bus mux: sequencer when granted, otherwise combinational CPU pass-through (quiet during reset)
    always_comb begin
        m_cyc_o = 1'b0;
        m_stb_o = 1'b0;
        m_we_o  = 1'b0;
        m_adr_o = 3'd0;
        m_dat_o = 8'h00;
        s_dat_o = 8'h00;
        s_ack_o = 1'b0;
        if (grant_q) begin
            m_cyc_o = seq_cyc;
            m_stb_o = seq_cyc;
            m_we_o  = seq_we;
            m_adr_o = seq_adr;
            m_dat_o = seq_dat;
        end else if (!rst_i) begin
            m_cyc_o = s_cyc_i;
            m_stb_o = s_stb_i;
            m_we_o  = s_we_i;
            m_adr_o = s_adr_i;
            m_dat_o = s_dat_i;
            s_dat_o = m_dat_i;
            s_ack_o = m_ack_i;
        end
    end

    // State registers; reset aborts any sequence and returns the bus to the CPU
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_OFF;
            phase_q <= PH_IDLE;
            pc_q    <= 5'd0;
            sstep_q <= 2'd0;
            cnt_q   <= 32'd0;
            pend_q  <= 1'b0;
            grant_q <= 1'b0;
`ifdef OLED_SEQ_TIMEOUT_EN
            err_q   <= 1'b0;
            poll_q  <= 12'd0;
`endif
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            pc_q    <= pc_d;
            sstep_q <= sstep_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            grant_q <= grant_d;
`ifdef OLED_SEQ_TIMEOUT_EN
            err_q   <= err_d;
            poll_q  <= poll_d;
`endif
        end
    end
endmodule

// File: tb/tb_oled_pwr_seq.sv
// Bench for oled_pwr_seq: oled_spi slave model with random ack/SPIF latency, bus monitor,
// and an expected-transaction list built from the power-up/power-down command tables.
module tb_oled_pwr_seq;
    localparam int TV = 5;
    localparam int TR = 7;
    localparam int TB = 9;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_i = 1'b0, stop_i = 1'b0;
    logic       busy_o, ready_o, err_o;
    logic       s_cyc_i = 1'b0, s_stb_i = 1'b0, s_we_i = 1'b0;
    logic [2:0] s_adr_i = 3'd0;
    logic [7:0] s_dat_i = 8'h00;
    logic [7:0] s_dat_o;
    logic       s_ack_o;
    logic       m_cyc_o, m_stb_o, m_we_o;
    logic [2:0] m_adr_o;
    logic [7:0] m_dat_o;
    logic [7:0] m_dat_i;
    logic       m_ack_i;

    always #5 clk = ~clk;

    oled_pwr_seq #(.T_VDD_CYC(TV), .T_RES_CYC(TR), .T_VBAT_CYC(TB), .SPCR_VAL(8'h50)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start_i), .stop_i(stop_i),
        .busy_o(busy_o), .ready_o(ready_o), .err_o(err_o),
        .s_cyc_i(s_cyc_i), .s_stb_i(s_stb_i), .s_we_i(s_we_i), .s_adr_i(s_adr_i),
        .s_dat_i(s_dat_i), .s_dat_o(s_dat_o), .s_ack_o(s_ack_o),
        .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_we_o(m_we_o), .m_adr_o(m_adr_o),
        .m_dat_o(m_dat_o), .m_dat_i(m_dat_i), .m_ack_i(m_ack_i)
    );

    // ---------------- oled_spi slave model ----------------
    int         ack_lat = 1, spif_min = 8, spif_max = 8;
    bit         spif_never = 1'b0;
    logic [7:0] r_ctrl, r_spcr, r_spsr;
    int         wcnt, spif_t;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ack_i <= 1'b0; r_ctrl <= 8'h0F; r_spcr <= 8'h00; r_spsr <= 8'h00;
            wcnt <= 0; spif_t <= 0;
        end else begin
            if (m_cyc_o && m_stb_o && !m_ack_i) begin
                if (wcnt + 1 >= ack_lat) begin m_ack_i <= 1'b1; wcnt <= 0; end
                else wcnt <= wcnt + 1;
            end else begin
                m_ack_i <= 1'b0;
            end
            if (spif_t == 1) r_spsr[7] <= 1'b1;
            if (spif_t > 0) spif_t <= spif_t - 1;
            if (m_cyc_o && m_stb_o && m_ack_i && m_we_o) begin
                case (m_adr_o)
                    3'd0: r_spcr <= m_dat_o;
                    3'd1: if (m_dat_o[7]) r_spsr[7] <= 1'b0;
                    3'd2: spif_t <= spif_never ? 0 : int'($urandom_range(spif_max, spif_min));
                    3'd5: r_ctrl <= m_dat_o;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        case (m_adr_o)
            3'd0:    m_dat_i = r_spcr;
            3'd1:    m_dat_i = r_spsr;
            3'd5:    m_dat_i = r_ctrl;
            default: m_dat_i = 8'h00;
        endcase
    end

    // ---------------- bus monitor ----------------
    typedef struct { logic [2:0] adr; logic [7:0] dat; int st; int ak; } wr_t;
    wr_t wq[$];
    int  cyc_n = 0;
    int  st_cyc = 0;
    bit  in_x = 1'b0;
    int  spsr_rd = 0, cpu_acks = 0, n_falls = 0, busy_fall = -1, ready_rise = -2;
    bit  ready_seen = 1'b0, ack_busy_viol = 1'b0;
    logic pbusy = 1'b0, pready = 1'b0;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (m_cyc_o && m_stb_o && !in_x) begin in_x = 1'b1; st_cyc = cyc_n; end
            if (m_cyc_o && m_stb_o && m_ack_i) begin
                in_x = 1'b0;
                if (m_we_o) wq.push_back('{adr: m_adr_o, dat: m_dat_o, st: st_cyc, ak: cyc_n});
                else if (m_adr_o == 3'd1 && busy_o) spsr_rd++;
            end
            if (s_ack_o) begin cpu_acks++; if (busy_o) ack_busy_viol = 1'b1; end
            if (ready_o) ready_seen = 1'b1;
            if (pbusy && !busy_o) begin n_falls++; busy_fall = cyc_n; end
            if (!pready && ready_o) ready_rise = cyc_n;
            pbusy = busy_o;
            pready = ready_o;
        end
    end

    // ---------------- reference: expected master writes ----------------
    logic [10:0] exp_q[$];
    int n_chk = 0, n_pass = 0;

    task automatic e_wr(input logic [2:0] a, input logic [7:0] d);
        exp_q.push_back({a, d});
    endtask
    task automatic e_send(input logic [7:0] b);
        e_wr(3'd2, b);
        e_wr(3'd1, 8'h80);
    endtask
    task automatic e_on();
        logic [7:0] g1[4];
        logic [7:0] g2[5];
        g1 = '{8'h8D, 8'h14, 8'hD9, 8'hF1};
        g2 = '{8'hA1, 8'hC8, 8'hDA, 8'h20, 8'hAF};
        e_wr(3'd5, 8'h0F); e_wr(3'd0, 8'h50); e_wr(3'd5, 8'h06);
        e_send(8'hAE);
        e_wr(3'd5, 8'h04); e_wr(3'd5, 8'h06);
        foreach (g1[i]) e_send(g1[i]);
        e_wr(3'd5, 8'h02);
        foreach (g2[i]) e_send(g2[i]);
    endtask
    task automatic e_off();
        e_send(8'hAE);
        e_wr(3'd5, 8'h06);
        e_wr(3'd5, 8'h0F);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    task automatic cmp_writes(input string tag);
        chk({tag, "_count"}, 32'(wq.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < wq.size(); i++)
            chk($sformatf("%s_wr%0d", tag, i), 32'({wq[i].adr, wq[i].dat}), 32'(exp_q[i]));
    endtask

    function automatic int find_wr(input logic [2:0] a, input logic [7:0] d);
        for (int i = 0; i < wq.size(); i++)
            if (wq[i].adr == a && wq[i].dat == d) return i;
        return -1;
    endfunction

    function automatic int gap_after(input int idx);
        if (idx < 0 || idx + 1 >= wq.size()) return -1;
        return wq[idx + 1].st - wq[idx].ak - 1;
    endfunction

    task automatic clear_mon();
        wq.delete(); exp_q.delete();
        ready_seen = 1'b0; n_falls = 0; spsr_rd = 0; cpu_acks = 0; ack_busy_viol = 1'b0;
        busy_fall = -1; ready_rise = -2;
    endtask

    task automatic pulse(input logic st, input logic sp);
        @(posedge clk); #1;
        start_i = st; stop_i = sp;
        @(posedge clk); #1;
        start_i = 1'b0; stop_i = 1'b0;
    endtask

    // sel: 0 busy low, 1 ready high, 2 err high, 3 s_ack high
    task automatic wait_for(input int sel, input int maxc, input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            @(posedge clk); #1;
            case (sel)
                0:       ok = !busy_o;
                1:       ok = ready_o;
                2:       ok = err_o;
                default: ok = s_ack_o;
            endcase
            if (ok) break;
        end
        chk({tag, "_reached"}, 32'(ok), 32'd1);
    endtask

    initial begin
        int d, j, jj;
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_ready", 32'(ready_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        chk("rst_mcyc", 32'(m_cyc_o), 32'd0);
        chk("rst_sack", 32'(s_ack_o), 32'd0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Power-up with 1-cycle ack, SPIF after 8; CPU read stalls mid-sequence
        clear_mon();
        ack_lat = 1; spif_min = 8; spif_max = 8;
        pulse(1'b1, 1'b0);
        chk("a_busy", 32'(busy_o), 32'd1);
        repeat (40) @(posedge clk);
        #1;
        chk("a_busy_at_cpu", 32'(busy_o), 32'd1);
        s_cyc_i = 1'b1; s_stb_i = 1'b1; s_we_i = 1'b0; s_adr_i = 3'd1;
        wait_for(3, 3000, "a_cpu_ack");
        chk("a_cpu_ack_busy", 32'(busy_o), 32'd0);
        chk("a_cpu_dat", 32'(s_dat_o), 32'h00);
        @(posedge clk); #1;
        s_cyc_i = 1'b0; s_stb_i = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("a_cpu_acks", 32'(cpu_acks), 32'd1);
        chk("a_ack_while_busy", 32'(ack_busy_viol), 32'd0);
        chk("a_ready", 32'(ready_o), 32'd1);
        chk("a_ready_busy_same", 32'(ready_rise), 32'(busy_fall));
        e_on();
        cmp_writes("a_on");
        chk("a_gap_vdd", 32'(gap_after(find_wr(3'd5, 8'h06))), 32'(TV));
        j = find_wr(3'd5, 8'h04);
        jj = (j < 0) ? -1 : j + 1;
        chk("a_gap_res_low", 32'(gap_after(j)), 32'(TR));
        chk("a_gap_res_high", 32'(gap_after(jj)), 32'(TR));
        chk("a_gap_vbat", 32'(gap_after(find_wr(3'd5, 8'h02))), 32'(TB));
        chk("a_gap_plain", 32'(gap_after(0)), 32'd1);
        chk("a_ctrl", 32'(r_ctrl), 32'h02);
        chk("a_spcr", 32'(r_spcr), 32'h50);

        // Power-down from ON
        clear_mon();
        pulse(1'b0, 1'b1);
        chk("off_busy", 32'(busy_o), 32'd1);
        chk("off_ready", 32'(ready_o), 32'd0);
        wait_for(0, 3000, "off_done");
        e_off();
        cmp_writes("off");
        chk("off_gap_vbat", 32'(gap_after(find_wr(3'd5, 8'h06))), 32'(TB));
        chk("off_ctrl", 32'(r_ctrl), 32'h0F);
        chk("off_ready_end", 32'(ready_o), 32'd0);

        // stop during power-up, randomized latencies
        for (int r = 0; r < 2; r++) begin
            clear_mon();
            ack_lat = int'($urandom_range(3, 1)); spif_min = 1; spif_max = 12;
            pulse(1'b1, 1'b0);
            d = int'($urandom_range(120, 20));
            repeat (d) @(posedge clk);
            #1;
            chk("b_busy_at_stop", 32'(busy_o), 32'd1);
            pulse(1'b0, 1'b1);
            wait_for(0, 6000, "b_done");
            repeat (2) @(posedge clk);
            #1;
            chk("b_ready_never", 32'(ready_seen), 32'd0);
            chk("b_ready_end", 32'(ready_o), 32'd0);
            chk("b_ctrl", 32'(r_ctrl), 32'h0F);
            e_on(); e_off();
            cmp_writes($sformatf("b%0d", r));
        end

        // start and stop together in OFF
        clear_mon();
        ack_lat = int'($urandom_range(2, 1));
        pulse(1'b1, 1'b1);
        wait_for(0, 8000, "c_done");
        repeat (2) @(posedge clk);
        #1;
        chk("c_busy_falls", 32'(n_falls), 32'd1);
        chk("c_ready_never", 32'(ready_seen), 32'd0);
        chk("c_ctrl", 32'(r_ctrl), 32'h0F);
        e_on(); e_off();
        cmp_writes("c");

`ifdef OLED_SEQ_TIMEOUT_EN
        // SPIF never sets: poll timeout
        clear_mon();
        ack_lat = 1; spif_never = 1'b1;
        pulse(1'b1, 1'b0);
        wait_for(2, 30000, "t_err");
        chk("t_err", 32'(err_o), 32'd1);
        chk("t_busy", 32'(busy_o), 32'd0);
        chk("t_ready", 32'(ready_o), 32'd0);
        chk("t_polls", 32'(spsr_rd), 32'd4096);
        e_wr(3'd5, 8'h0F); e_wr(3'd0, 8'h50); e_wr(3'd5, 8'h06); e_wr(3'd2, 8'hAE); e_wr(3'd5, 8'h0F);
        cmp_writes("t");
        chk("t_ctrl", 32'(r_ctrl), 32'h0F);
        spif_never = 1'b0; spif_min = 2; spif_max = 6;
        pulse(1'b1, 1'b0);
        chk("t_err_clr", 32'(err_o), 32'd0);
        chk("t_restart_busy", 32'(busy_o), 32'd1);
        wait_for(1, 6000, "t_ready");
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
